// File: rtl/seg_scan_decoder_if.sv
// Display-scan inputs and decoded readback outputs of seg_scan_decoder.
// The master drives the scan; the slave is the decoder.
interface seg_scan_decoder_if #(
    parameter int unsigned DWELL_W = 8
) ();
    logic [3:0]         anode;
    logic [7:0]         seg_display;
    logic [7:0]         leds;
    logic               clock_1s;
    logic [3:0]         digit0;
    logic [3:0]         digit1;
    logic [3:0]         digit2;
    logic [3:0]         digit3;
    logic [3:0]         digit_valid;
    logic [3:0]         digit_blank;
    logic               frame_done;
    logic               anode_err;
    logic               seg_err;
    logic               phase_change;
    logic [DWELL_W-1:0] last_dwell;
    logic [DWELL_W-1:0] cur_dwell;

    modport master (
        output anode, seg_display, leds, clock_1s,
        input  digit0, digit1, digit2, digit3, digit_valid, digit_blank,
               frame_done, anode_err, seg_err, phase_change, last_dwell, cur_dwell
    );

    modport slave (
        input  anode, seg_display, leds, clock_1s,
        output digit0, digit1, digit2, digit3, digit_valid, digit_blank,
               frame_done, anode_err, seg_err, phase_change, last_dwell, cur_dwell
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// Recovers the four digits from an active-low anode/segment scan and times
// each signal-light phase in 1 s ticks.
module seg_scan_decoder #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned DWELL_W       = 8
) (
    input logic                clk,
    input logic                rst,
    seg_scan_decoder_if.slave  bus
);
    localparam int unsigned         CNT_W     = 8;
    localparam int unsigned         KEY_W     = 11;
    localparam logic [CNT_W-1:0]    CNT_SAT   = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0]    CNT_CAP   = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [KEY_W-1:0]    IDLE_KEY  = {4'hF, 7'h7F};
    localparam logic [DWELL_W-1:0]  DWELL_MAX = '1;

    logic [3:0]         anode_q, anode_d;
    logic [6:0]         seg_q, seg_d;
    logic [7:0]         leds_q, leds_d;
    logic               clk1_q, clk1_d;
    logic [KEY_W-1:0]   key_prev_q, key_prev_d;
    logic [CNT_W-1:0]   stab_q, stab_d;
    logic [3:0]         digit_q [4];
    logic [3:0]         digit_d [4];
    logic [3:0]         valid_q, valid_d;
    logic [3:0]         blank_q, blank_d;
    logic [3:0]         mask_q, mask_d;
    logic               frame_done_q, frame_done_d;
    logic               anode_err_q, anode_err_d;
    logic               seg_err_q, seg_err_d;
    logic [7:0]         leds_prev_q, leds_prev_d;
    logic               loaded_q, loaded_d;
    logic               base_q, base_d;
    logic               chg_q, chg_d;
    logic               clk1_prev_q, clk1_prev_d;
    logic               tick_q, tick_d;
    logic               phase_change_q, phase_change_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DWELL_W-1:0] last_dwell_q, last_dwell_d;
    logic [DWELL_W-1:0] cur_dwell_q, cur_dwell_d;

    logic [KEY_W-1:0]   key_c;
    logic               stable_c;
    logic               capture_c;
    logic               hit_c;
    logic               anode_bad_c;
    logic [1:0]         sel_c;
    logic               dec_ok_c;
    logic [3:0]         dec_val_c;
    logic [3:0]         mask_c;

    always_comb begin
        anode_d        = bus.anode;
        seg_d          = bus.seg_display[6:0];
        leds_d         = bus.leds;
        clk1_d         = bus.clock_1s;
        key_c          = {anode_q, seg_q};
        stable_c       = (key_c == key_prev_q);
        key_prev_d     = key_c;
        capture_c      = stable_c && (stab_q == CNT_CAP);
        for (int i = 0; i < 4; i++) digit_d[i] = digit_q[i];
        valid_d        = valid_q;
        blank_d        = blank_q;
        mask_d         = mask_q;
        frame_done_d   = 1'b0;
        anode_err_d    = 1'b0;
        seg_err_d      = 1'b0;
        hit_c          = 1'b0;
        anode_bad_c    = 1'b0;
        sel_c          = 2'd0;
        dec_ok_c       = 1'b1;
        dec_val_c      = 4'd0;

        if (!stable_c)             stab_d = '0;
        else if (stab_q == CNT_SAT) stab_d = stab_q;
        else                       stab_d = stab_q + CNT_W'(1);

        case (anode_q)
            4'b1110: begin hit_c = 1'b1; sel_c = 2'd0; end
            4'b1101: begin hit_c = 1'b1; sel_c = 2'd1; end
            4'b1011: begin hit_c = 1'b1; sel_c = 2'd2; end
            4'b0111: begin hit_c = 1'b1; sel_c = 2'd3; end
            4'b1111: hit_c = 1'b0;
            default: anode_bad_c = 1'b1;
        endcase

        case (seg_q)
            7'h40:   dec_val_c = 4'd0;
            7'h79:   dec_val_c = 4'd1;
            7'h24:   dec_val_c = 4'd2;
            7'h30:   dec_val_c = 4'd3;
            7'h19:   dec_val_c = 4'd4;
            7'h12:   dec_val_c = 4'd5;
            7'h02:   dec_val_c = 4'd6;
            7'h78:   dec_val_c = 4'd7;
            7'h00:   dec_val_c = 4'd8;
            7'h10:   dec_val_c = 4'd9;
            default: dec_ok_c  = 1'b0;
        endcase

        mask_c = mask_q | (4'b0001 << sel_c);

        // One capture per stable run; blank and bad codes hold the digit value.
        if (capture_c) begin
            anode_err_d = anode_bad_c;
            if (hit_c) begin
                if (dec_ok_c) begin
                    digit_d[sel_c] = dec_val_c;
                    valid_d[sel_c] = 1'b1;
                    blank_d[sel_c] = 1'b0;
                end else if (seg_q == 7'h7F) begin
                    valid_d[sel_c] = 1'b0;
                    blank_d[sel_c] = 1'b1;
                end else begin
                    seg_err_d      = 1'b1;
                    valid_d[sel_c] = 1'b0;
                    blank_d[sel_c] = 1'b0;
                end
                if (mask_c == 4'hF) begin
                    frame_done_d = 1'b1;
                    mask_d       = 4'h0;
                end else begin
                    mask_d = mask_c;
                end
            end
        end

        // Phase path: the first leds sample after reset only seeds the compare.
        leds_prev_d    = leds_q;
        clk1_prev_d    = clk1_q;
        loaded_d       = 1'b1;
        base_d         = base_q & ~loaded_q;
        chg_d          = (leds_q != leds_prev_q) && !base_q;
        tick_d         = clk1_q & ~clk1_prev_q;
        phase_change_d = chg_q;
        last_dwell_d   = last_dwell_q;
        dwell_d        = dwell_q;
        if (chg_q) begin
            last_dwell_d = dwell_q;
            dwell_d      = '0;
        end else if (tick_q && (dwell_q != DWELL_MAX)) begin
            dwell_d = dwell_q + DWELL_W'(1);
        end
        cur_dwell_d = dwell_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            anode_q        <= 4'hF;
            seg_q          <= 7'h7F;
            leds_q         <= '0;
            clk1_q         <= 1'b0;
            key_prev_q     <= IDLE_KEY;
            stab_q         <= '0;
            for (int i = 0; i < 4; i++) digit_q[i] <= '0;
            valid_q        <= '0;
            blank_q        <= '0;
            mask_q         <= '0;
            frame_done_q   <= 1'b0;
            anode_err_q    <= 1'b0;
            seg_err_q      <= 1'b0;
            leds_prev_q    <= '0;
            loaded_q       <= 1'b0;
            base_q         <= 1'b1;
            chg_q          <= 1'b0;
            clk1_prev_q    <= 1'b0;
            tick_q         <= 1'b0;
            phase_change_q <= 1'b0;
            dwell_q        <= '0;
            last_dwell_q   <= '0;
            cur_dwell_q    <= '0;
        end else begin
            anode_q        <= anode_d;
            seg_q          <= seg_d;
            leds_q         <= leds_d;
            clk1_q         <= clk1_d;
            key_prev_q     <= key_prev_d;
            stab_q         <= stab_d;
            for (int i = 0; i < 4; i++) digit_q[i] <= digit_d[i];
            valid_q        <= valid_d;
            blank_q        <= blank_d;
            mask_q         <= mask_d;
            frame_done_q   <= frame_done_d;
            anode_err_q    <= anode_err_d;
            seg_err_q      <= seg_err_d;
            leds_prev_q    <= leds_prev_d;
            loaded_q       <= loaded_d;
            base_q         <= base_d;
            chg_q          <= chg_d;
            clk1_prev_q    <= clk1_prev_d;
            tick_q         <= tick_d;
            phase_change_q <= phase_change_d;
            dwell_q        <= dwell_d;
            last_dwell_q   <= last_dwell_d;
            cur_dwell_q    <= cur_dwell_d;
        end
    end

    assign bus.digit0       = digit_q[0];
    assign bus.digit1       = digit_q[1];
    assign bus.digit2       = digit_q[2];
    assign bus.digit3       = digit_q[3];
    assign bus.digit_valid  = valid_q;
    assign bus.digit_blank  = blank_q;
    assign bus.frame_done   = frame_done_q;
    assign bus.anode_err    = anode_err_q;
    assign bus.seg_err      = seg_err_q;
    assign bus.phase_change = phase_change_q;
    assign bus.last_dwell   = last_dwell_q;
    assign bus.cur_dwell    = cur_dwell_q;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: a run-length reference model queues
// timestamped expectations, and a negedge monitor pops and compares them.
module tb_seg_scan_decoder;
    localparam int unsigned S    = 4;
    localparam int unsigned DW   = 8;
    localparam int unsigned DMAX = (1 << DW) - 1;

    typedef struct {
        int unsigned cyc;
        logic [15:0] digs;
        logic [3:0]  val;
        logic [3:0]  blk;
        logic        fd;
        logic        ae;
        logic        se;
    } cap_t;

    typedef struct {
        int unsigned cyc;
        logic [DW-1:0] v;
    } dw_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_e = 1'b1;
    int unsigned cyc = 0;
    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_e <= rst;
    end

    seg_scan_decoder_if #(.DWELL_W(DW)) bus ();
    seg_scan_decoder #(.SETTLE_CYCLES(S), .DWELL_W(DW)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    cap_t capq[$];
    dw_t  phq[$];
    dw_t  curq[$];

    logic [6:0] codes [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    // Driven values
    logic [3:0] a_in = 4'hF;
    logic [7:0] s_in = 8'hFF;
    logic [7:0] l_in = 8'h00;
    logic       c_in = 1'b0;

    // Reference model state
    logic [15:0] m_digs;
    logic [3:0]  m_val, m_blk, m_mask;
    logic [10:0] m_key;
    int unsigned m_run;
    bit          m_first;
    logic [7:0]  m_leds;
    logic        m_c1s;
    int unsigned m_dwell;

    // State the outputs should currently show
    logic [15:0]   c_digs = '0;
    logic [3:0]    c_val = '0, c_blk = '0;
    logic [DW-1:0] c_last = '0;
    int fd_seen = 0, ae_seen = 0, se_seen = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    task automatic model_reset();
        m_digs = '0; m_val = '0; m_blk = '0; m_mask = '0;
        m_key = {4'hF, 7'h7F}; m_run = cyc + 1;
        m_first = 1'b1; m_leds = '0; m_c1s = 1'b0; m_dwell = 0;
    endtask

    // Capture of the held value, applied from spec rules to the model state.
    task automatic model_capture(input int unsigned t);
        logic [3:0] a;
        logic [6:0] sg;
        int d, dv;
        cap_t r;
        a  = m_key[10:7];
        sg = m_key[6:0];
        if (a == 4'hF) return;
        r.fd = 1'b0; r.ae = 1'b0; r.se = 1'b0;
        d = -1;
        if ($countones(~a) == 1)
            for (int k = 0; k < 4; k++) if (!a[k]) d = k;
        if (d < 0) begin
            r.ae = 1'b1;
        end else begin
            dv = -1;
            for (int k = 0; k < 10; k++) if (codes[k] == sg) dv = k;
            if (dv >= 0) begin
                m_digs[d*4 +: 4] = 4'(dv); m_val[d] = 1'b1; m_blk[d] = 1'b0;
            end else if (sg == 7'h7F) begin
                m_val[d] = 1'b0; m_blk[d] = 1'b1;
            end else begin
                r.se = 1'b1; m_val[d] = 1'b0; m_blk[d] = 1'b0;
            end
            m_mask[d] = 1'b1;
            if (m_mask == 4'hF) begin r.fd = 1'b1; m_mask = '0; end
        end
        r.cyc = t; r.digs = m_digs; r.val = m_val; r.blk = m_blk;
        capq.push_back(r);
    endtask

    // Apply inputs for the next edge, advance the model, wait past the edge.
    task automatic step();
        int unsigned e;
        logic [10:0] key;
        bit chg, rise;
        dw_t t;
        bus.anode = a_in; bus.seg_display = s_in; bus.leds = l_in; bus.clock_1s = c_in;
        e = cyc + 1;
        key = {a_in, s_in[6:0]};
        if (key != m_key) begin m_key = key; m_run = e; end
        if (e - m_run == S) model_capture(e + 1);
        chg = !m_first && (l_in != m_leds);
        m_first = 1'b0;
        m_leds = l_in;
        rise = c_in && !m_c1s;
        m_c1s = c_in;
        if (chg) begin
            t.cyc = e + 2; t.v = DW'(m_dwell); phq.push_back(t);
            m_dwell = 0;
        end else if (rise && m_dwell < DMAX) begin
            m_dwell++;
        end
        t.cyc = e + 3; t.v = DW'(m_dwell); curq.push_back(t);
        @(posedge clk); #1;
    endtask

    task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n);
        a_in = a; s_in = s;
        repeat (n) step();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            c_in = 1'b1; step(); step();
            c_in = 1'b0; step(); step();
        end
    endtask

    // Drop expectations not yet due; the reset edge supersedes them.
    task automatic do_reset();
        int unsigned now;
        now = cyc;
        while (capq.size() > 0 && capq[capq.size()-1].cyc > now) void'(capq.pop_back());
        while (phq.size()  > 0 && phq[phq.size()-1].cyc   > now) void'(phq.pop_back());
        while (curq.size() > 0 && curq[curq.size()-1].cyc > now) void'(curq.pop_back());
        rst = 1'b1;
        bus.anode = a_in; bus.seg_display = s_in; bus.leds = l_in; bus.clock_1s = c_in;
        @(posedge clk); #1;
        model_reset();
        rst = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        cap_t r;
        dw_t  p;
        logic fd, ae, se, pc;
        if (rst_e && mon_en) begin
            c_digs = '0; c_val = '0; c_blk = '0; c_last = '0;
            chk("rst_digits", 32'({bus.digit3, bus.digit2, bus.digit1, bus.digit0}), 32'h0);
            chk("rst_valid_blank", 32'({bus.digit_valid, bus.digit_blank}), 32'h0);
            chk("rst_pulses", 32'({bus.frame_done, bus.anode_err, bus.seg_err, bus.phase_change}), 32'h0);
            chk("rst_dwell", 32'({bus.last_dwell, bus.cur_dwell}), 32'h0);
        end else if (mon_en) begin
            fd = 1'b0; ae = 1'b0; se = 1'b0; pc = 1'b0;
            if (capq.size() > 0 && capq[0].cyc == cyc) begin
                r = capq.pop_front();
                c_digs = r.digs; c_val = r.val; c_blk = r.blk;
                fd = r.fd; ae = r.ae; se = r.se;
            end
            chk("digits", 32'({bus.digit3, bus.digit2, bus.digit1, bus.digit0}), 32'(c_digs));
            chk("digit_valid", 32'(bus.digit_valid), 32'(c_val));
            chk("digit_blank", 32'(bus.digit_blank), 32'(c_blk));
            chk("pulses_fd_ae_se", 32'({bus.frame_done, bus.anode_err, bus.seg_err}), 32'({fd, ae, se}));
            if (phq.size() > 0 && phq[0].cyc == cyc) begin
                p = phq.pop_front();
                c_last = p.v; pc = 1'b1;
            end
            chk("phase_change", 32'(bus.phase_change), 32'(pc));
            chk("last_dwell", 32'(bus.last_dwell), 32'(c_last));
            if (curq.size() > 0 && curq[0].cyc == cyc) begin
                p = curq.pop_front();
                chk("cur_dwell", 32'(bus.cur_dwell), 32'(p.v));
            end
            if (bus.frame_done) fd_seen++;
            if (bus.anode_err)  ae_seen++;
            if (bus.seg_err)    se_seen++;
        end
    end

    initial begin
        logic [3:0] an_list [8] = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hF, 4'hC, 4'h0, 4'h5};
        logic [3:0] ra;
        logic [7:0] rs;
        int n;
        model_reset();
        bus.anode = a_in; bus.seg_display = s_in; bus.leds = l_in; bus.clock_1s = c_in;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        do_reset();

        // Full scan of 0,1,2,3
        fd_seen = 0;
        hold(4'hE, 8'hC0, 10); hold(4'hD, 8'hF9, 10);
        hold(4'hB, 8'hA4, 10); hold(4'h7, 8'hB0, 10);
        hold(4'hF, 8'hFF, 6);
        chk("t1_digits", 32'({bus.digit3, bus.digit2, bus.digit1, bus.digit0}), 32'h3210);
        chk("t1_valid", 32'(bus.digit_valid), 32'hF);
        chk("t1_frames", 32'(fd_seen), 32'd1);

        // Ghost rejection: 4-cycle hold is never captured
        hold(4'hE, 8'hA4, 4); hold(4'hE, 8'hB0, 10); hold(4'hF, 8'hFF, 4);
        chk("t2_digit0", 32'(bus.digit0), 32'd3);

        // Illegal and idle anode patterns
        ae_seen = 0;
        hold(4'hC, 8'hC0, 10); hold(4'hF, 8'hC0, 10);
        chk("t3_anode_err", 32'(ae_seen), 32'd1);
        chk("t3_digits", 32'({bus.digit3, bus.digit2, bus.digit1, bus.digit0}), 32'h3213);

        // Blank then undecodable on digit 1
        se_seen = 0;
        hold(4'hD, 8'hFF, 10);
        chk("t4_blank1", 32'(bus.digit_blank[1]), 32'd1);
        hold(4'hD, 8'h88, 10); hold(4'hF, 8'hFF, 4);
        chk("t4_seg_err", 32'(se_seen), 32'd1);
        chk("t4_valid1", 32'(bus.digit_valid[1]), 32'd0);
        chk("t4_digit1", 32'(bus.digit1), 32'd1);

        // Phase timing with a tick coincident with the change
        l_in = 8'h01; step(); step();
        ticks(5);
        l_in = 8'h02; c_in = 1'b1; step();
        c_in = 1'b0; repeat (6) step();
        chk("t5_last_dwell", 32'(bus.last_dwell), 32'd5);
        chk("t5_cur_dwell", 32'(bus.cur_dwell), 32'd0);

        // Saturation, then reset mid-scan
        ticks(300);
        repeat (4) step();
        chk("t6_saturate", 32'(bus.cur_dwell), 32'(DMAX));
        hold(4'hE, 8'hF9, 3);
        do_reset();
        fd_seen = 0;
        hold(4'hE, 8'hF9, 10);
        chk("t6_post_reset_digit0", 32'(bus.digit0), 32'd1);

        // Randomized scan, light changes, ticks and occasional reset
        for (int it = 0; it < 200; it++) begin
            ra = an_list[$urandom_range(0, 7)];
            case ($urandom_range(0, 3))
                0, 1:    rs = {1'($urandom_range(0, 1)), codes[$urandom_range(0, 9)]};
                2:       rs = 8'hFF;
                default: rs = 8'($urandom);
            endcase
            n = $urandom_range(1, 9);
            a_in = ra; s_in = rs;
            for (int j = 0; j < n; j++) begin
                if ($urandom_range(0, 24) == 0) l_in = 8'($urandom);
                c_in = 1'($urandom_range(0, 1));
                step();
            end
            if ($urandom_range(0, 79) == 0) do_reset();
        end

        hold(4'hF, 8'hFF, 12);
        chk("drain_capture_queue", 32'(capq.size()), 32'd0);
        chk("drain_phase_queue", 32'(phq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
